// File: rtl/seq_det_scheduler.sv
// Byte-stream front end for the serial sequence detector: serializes bytes MSB-first,
// matches a programmable pattern on the bit history, counts matches and raises a threshold irq.
module seq_det_scheduler #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               irq_clr,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               bit_out,
    output logic               bit_vld,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               thresh_irq,
    output logic               busy
);

    localparam int HC_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [MAX_LEN-1:0]   r_pat;
    logic [3:0]           r_len;
    logic                 r_ovl;
    logic [CNT_W-1:0]     r_thr;

    logic [7:0]           r_byte;
    logic [2:0]           r_idx;
    logic                 r_stop_pend;
    logic [MAX_LEN-1:0]   r_hist;
    logic [HC_W-1:0]      r_hist_cnt;
    logic                 r_match_p1;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_irq;

    logic                 w_shift;
    logic                 w_accept;
    logic                 w_bit;
    logic [MAX_LEN-1:0]   w_hist_nxt;
    logic [HC_W-1:0]      w_hc_inc;
    logic [HC_W-1:0]      w_leff;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_hit;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_irq_set;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [HC_W-1:0] sat_hist(input logic [HC_W-1:0] v);
        return (v == HC_W'(MAX_LEN)) ? v : v + HC_W'(1);
    endfunction

    function automatic logic [HC_W-1:0] eff_len(input logic [3:0] len);
        return (int'(len) > MAX_LEN) ? HC_W'(MAX_LEN) : HC_W'(len);
    endfunction

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [HC_W-1:0] leff);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(leff)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign w_shift    = (r_state == SHIFT);
    assign w_accept   = (r_state == RUN) && s_valid && !stop;
    assign w_bit      = r_byte[r_idx];
    assign w_hist_nxt = {r_hist[MAX_LEN-2:0], w_bit};
    assign w_hc_inc   = sat_hist(r_hist_cnt);
    assign w_leff     = eff_len(r_len);
    assign w_mask     = len_mask(w_leff);

    // Match is judged on the history as it will look after this bit is shifted in.
    assign w_hit      = w_shift && (w_leff != '0) && (w_hc_inc >= w_leff) &&
                        ((w_hist_nxt & w_mask) == (r_pat & w_mask));
    assign w_cnt_inc  = sat_cnt(r_cnt);
    assign w_irq_set  = w_hit && (r_thr != '0) && (w_cnt_inc == r_thr);

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        bit_vld     = 1'b0;
        bit_out     = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                // Ready is withheld while stop is high so a stopping cycle never completes a handshake.
                s_ready = !stop;
                if (stop)         w_state_nxt = IDLE;
                else if (s_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                bit_vld = 1'b1;
                bit_out = w_bit;
                if (r_idx == 3'd0) w_state_nxt = (r_stop_pend || stop) ? IDLE : RUN;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pat       <= MAX_LEN'(5'b11001);
            r_len       <= 4'd5;
            r_ovl       <= 1'b1;
            r_thr       <= '0;
            r_byte      <= '0;
            r_idx       <= '0;
            r_stop_pend <= 1'b0;
            r_hist      <= '0;
            r_hist_cnt  <= '0;
            r_match_p1  <= 1'b0;
            r_cnt       <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_match_p1 <= w_hit;

            if ((r_state == IDLE) && cfg_we) begin
                r_pat <= cfg_pattern;
                r_len <= cfg_len;
                r_ovl <= cfg_overlap;
                r_thr <= cfg_thresh;
            end

            if ((r_state == IDLE) && start) begin
                r_hist      <= '0;
                r_hist_cnt  <= '0;
                r_stop_pend <= 1'b0;
            end

            if (w_accept) begin
                r_byte <= s_data;
                r_idx  <= 3'd7;
            end

            // Shift stage: history advances; non-overlap mode forgets bits already used by a match.
            if (w_shift) begin
                r_hist     <= w_hist_nxt;
                r_hist_cnt <= (w_hit && !r_ovl) ? '0 : w_hc_inc;
                r_idx      <= r_idx - 3'd1;
                if (r_idx == 3'd0) r_stop_pend <= 1'b0;
                else if (stop)     r_stop_pend <= 1'b1;
            end

            if ((r_state == IDLE) && start) r_cnt <= '0;
            else if (w_hit)                 r_cnt <= w_cnt_inc;

            if ((r_state == IDLE) && start) r_irq <= 1'b0;
            else if (w_irq_set)             r_irq <= 1'b1;
            else if (irq_clr)               r_irq <= 1'b0;
        end
    end

    assign match      = r_match_p1;
    assign match_cnt  = r_cnt;
    assign thresh_irq = r_irq;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed and randomized checks of seq_det_scheduler against a bit-queue reference model.
module tb_seq_det_scheduler;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               start;
    logic               stop;
    logic               irq_clr;
    logic [7:0]         s_data;
    logic               s_valid;
    logic               s_ready;
    logic               bit_out;
    logic               bit_vld;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               thresh_irq;
    logic               busy;

    always #5 clk = ~clk;

    seq_det_scheduler #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop), .irq_clr(irq_clr), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .bit_out(bit_out), .bit_vld(bit_vld),
        .match(match), .match_cnt(match_cnt), .thresh_irq(thresh_irq), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: latched config, bits seen since session start (or last non-overlap match).
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_thr;
    int         m_cnt;
    bit         m_irq;
    bit         m_idle;
    bit         q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pat  = 8'b0001_1001;
        m_len  = 5;
        m_ovl  = 1'b1;
        m_thr  = 0;
        m_cnt  = 0;
        m_irq  = 1'b0;
        m_idle = 1'b1;
        q.delete();
    endtask

    task automatic model_push(input bit b, output bit hit);
        int leff;
        q.push_back(b);
        leff = (m_len > MAX_LEN) ? MAX_LEN : m_len;
        hit  = 1'b0;
        if (leff > 0 && q.size() >= leff) begin
            hit = 1'b1;
            for (int j = 0; j < leff; j++)
                if (q[q.size() - 1 - j] != m_pat[j]) hit = 1'b0;
        end
        if (hit && !m_ovl) q.delete();
        if (q.size() > 32) void'(q.pop_front());
        if (hit) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
        end
    endtask

    task automatic do_start(input bit we, input logic [7:0] pat, input int len,
                            input bit ovl, input int thr);
        cfg_we      = we;
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        cfg_thresh  = CNT_W'(thr);
        start       = 1'b1;
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        if (we) begin
            m_pat = pat; m_len = len; m_ovl = ovl; m_thr = thr;
        end
        m_cnt = 0; m_irq = 1'b0; m_idle = 1'b0; q.delete();
        chk("start_busy", busy, 1);
        chk("start_cnt", match_cnt, 0);
        chk("start_irq", thresh_irq, 0);
    endtask

    task automatic cfg_write(input logic [7:0] pat, input int len, input bit ovl, input int thr);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        cfg_thresh  = CNT_W'(thr);
        tick();
        cfg_we = 1'b0;
        if (m_idle) begin
            m_pat = pat; m_len = len; m_ovl = ovl; m_thr = thr;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_idx);
        bit hit;
        s_data  = b;
        s_valid = 1'b1;
        chk("accept_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
            chk("bit_vld", bit_vld, 1);
            chk("bit_out", bit_out, b[i]);
            chk("shift_ready", s_ready, 0);
            chk("shift_busy", busy, 1);
            stop = (i == stop_idx);
            model_push(b[i], hit);
            tick();
            stop = 1'b0;
            chk("match", match, hit);
            chk("match_cnt", match_cnt, m_cnt);
            chk("irq", thresh_irq, m_irq);
        end
        if (stop_idx >= 0 && stop_idx <= 7) m_idle = 1'b1;
        chk("post_byte_busy", busy, !m_idle);
    endtask

    task automatic gap(input int n, input bit rand_clr);
        bit c;
        for (int k = 0; k < n; k++) begin
            c       = rand_clr && ($urandom_range(0, 1) == 1);
            irq_clr = c;
            tick();
            irq_clr = 1'b0;
            if (c) m_irq = 1'b0;
            chk("gap_match", match, 0);
            chk("gap_cnt", match_cnt, m_cnt);
            chk("gap_irq", thresh_irq, m_irq);
            chk("gap_busy", busy, !m_idle);
        end
    endtask

    task automatic stop_run();
        stop    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        tick();
        stop    = 1'b0;
        s_valid = 1'b0;
        m_idle  = 1'b1;
        chk("stop_busy", busy, 0);
        chk("stop_bitvld", bit_vld, 0);
        chk("stop_cnt", match_cnt, m_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_thresh = '0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0; s_data = '0; s_valid = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_bitvld", bit_vld, 0);
        chk("rst_bitout", bit_out, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_irq", thresh_irq, 0);
        rst = 1'b0;
        tick();

        // Default config, overlapping: matches after stream bits 5 and 9.
        do_start(1'b0, 8'h00, 0, 1'b0, 0);
        send_byte(8'h66, -1);
        send_byte(8'h40, -1);
        chk("ovl_cnt", match_cnt, 2);
        stop_run();

        // Non-overlapping: only the first match survives.
        do_start(1'b1, 8'h19, 5, 1'b0, 0);
        send_byte(8'h66, -1);
        send_byte(8'h40, -1);
        chk("novl_cnt", match_cnt, 1);
        stop_run();

        // Threshold interrupt, clear, and no re-set at count 3.
        do_start(1'b1, 8'h19, 5, 1'b1, 2);
        send_byte(8'h66, -1);
        send_byte(8'h40, -1);
        chk("thr_irq_set", thresh_irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        m_irq = 1'b0;
        chk("thr_irq_clr", thresh_irq, 0);
        send_byte(8'hC8, -1);
        chk("thr_cnt3", match_cnt, 3);
        chk("thr_irq_stay", thresh_irq, 0);
        stop_run();
        gap(2, 1'b0);
        chk("idle_hold_cnt", match_cnt, 3);

        // Stop during shift: byte completes, match at bit 5 still counted.
        do_start(1'b1, 8'h19, 5, 1'b1, 0);
        send_byte(8'h66, 4);
        chk("stop_shift_busy", busy, 0);
        chk("stop_shift_cnt", match_cnt, 1);
        gap(1, 1'b0);

        // Config write while running is ignored.
        do_start(1'b1, 8'h19, 5, 1'b1, 0);
        cfg_write(8'h01, 3, 1'b1, 0);
        send_byte(8'h66, -1);
        send_byte(8'h40, -1);
        chk("busy_cfg_cnt", match_cnt, 2);
        stop_run();

        // Counter saturation with a one-bit pattern.
        do_start(1'b1, 8'h01, 1, 1'b1, 0);
        for (int k = 0; k < 33; k++) send_byte(8'hFF, -1);
        chk("sat_cnt", match_cnt, CNT_MAX);
        stop_run();

        // Reset mid-byte returns to defaults.
        do_start(1'b1, 8'h01, 1, 1'b0, 1);
        s_data = 8'h66; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bitvld", bit_vld, 0);
        chk("mid_rst_cnt", match_cnt, 0);
        chk("mid_rst_irq", thresh_irq, 0);
        do_start(1'b0, 8'h00, 0, 1'b0, 0);
        send_byte(8'h66, -1);
        send_byte(8'h40, -1);
        chk("mid_rst_default_cfg", match_cnt, 2);
        stop_run();

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            int nb;
            do_start(1'b1, 8'($urandom), $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 5));
            nb = $urandom_range(3, 7);
            for (int k = 0; k < nb; k++) begin
                int sidx;
                sidx = ($urandom_range(0, 7) == 0 && k != nb - 1) ? $urandom_range(0, 7) : -1;
                send_byte(8'($urandom), sidx);
                if (m_idle) break;
                gap($urandom_range(0, 2), 1'b1);
            end
            if (!m_idle) stop_run();
            gap(2, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Front-end controller for the serial overlapping sequence detector.
- Accepts bytes over a valid/ready stream and serializes them MSB-first, one bit per clock.
- Runs a programmable pattern match (length 1..MAX_LEN, overlapping or non-overlapping) and counts matches.
- Raises a sticky threshold interrupt; sequences start/stop of detection sessions for the surrounding system.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; sets the width of the pattern and history registers.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe; honoured only in IDLE.
- cfg_pattern  input  MAX_LEN  pattern; the low cfg_len bits are used, bit 0 = most recent bit.
- cfg_len  input  4  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_thresh  input  CNT_W  match count that sets irq; 0 disables irq.
- start  input  1  begin session (IDLE only).
- stop  input  1  end session.
- irq_clr  input  1  clear thresh_irq.
- s_data  input  8  stream byte.
- s_valid  input  1  stream byte valid.
- s_ready  output  1  scheduler can accept a byte.
- bit_out  output  1  serial bit currently being presented to the detector.
- bit_vld  output  1  bit_out valid this cycle.
- match  output  1  one-cycle pulse per detected match.
- match_cnt  output  CNT_W  matches this session, saturating.
- thresh_irq  output  1  sticky threshold interrupt.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; history and bit counters 0.
  - Config registers: pattern = 5'b11001 (zero-extended), len = 5, overlap = 1, thresh = 0.
- FSM states IDLE, RUN, SHIFT.
- IDLE:
  - cfg_we latches all cfg_* inputs.
  - start moves to RUN the next cycle and clears history, hist_cnt, match_cnt and thresh_irq.
  - cfg_we and start in the same cycle: config latches first; the session uses the new config.
- RUN:
  - s_ready = 1.
  - On s_valid & s_ready, latch s_data and go to SHIFT with bit index 7.
  - stop (with or without s_valid) goes to IDLE; the byte is not accepted.
- SHIFT:
  - s_ready = 0, bit_vld = 1, bit_out = byte[idx], idx counts 7 down to 0.
  - history <= {history[MAX_LEN-2:0], bit_out}; hist_cnt increments, saturating at MAX_LEN.
  - After idx = 0, return to RUN. Throughput is one byte per 9 cycles.
- Match rule:
  - A match occurs when hist_cnt >= Leff and history[Leff-1:0] == pattern[Leff-1:0], evaluated on the updated history.
  - match is registered: it pulses the cycle after the SHIFT cycle that carried the completing bit.
  - Leff = min(cfg_len, MAX_LEN); Leff = 0 disables matching.
- Non-overlap mode: on a match, hist_cnt resets to 0, so bits of the matched sequence cannot be reused.
- Overlap mode: history and hist_cnt are unchanged by a match.
- History persists across byte boundaries within a session.
- Counter and interrupt:
  - match_cnt increments with each match pulse and saturates at all-ones.
  - thresh_irq sets when the incremented count equals cfg_thresh (cfg_thresh != 0).
  - irq_clr clears thresh_irq; if irq_clr and a set condition occur in the same cycle, set wins.
- stop during SHIFT is recorded as pending. The current byte completes, then the FSM goes to IDLE instead of RUN. A match from the final bit still pulses and counts.
- match_cnt and thresh_irq hold their values in IDLE until the next start.
- rst asserted mid-operation returns everything to reset values on the next edge; an in-flight byte is discarded.

Test Plan:
- Overlap, default config:
  - Stimulus: start; bytes 0x66, 0x40 (bits 0110011001000000).
  - Response: match pulses after bit 5 of byte 0 and after bit 9 (byte 1, bit 1); match_cnt = 2.
- Non-overlap: same stream with cfg_overlap = 0 → exactly one match, after bit 5; match_cnt = 1.
- Threshold interrupt:
  - Stimulus: cfg_thresh = 2, overlap stream as above.
  - Response: thresh_irq rises with the second match count. irq_clr drops it. A further byte 0xC8 (11001000) re-sets it? No: count 3 ≠ 2, so irq stays 0.
- Stop during SHIFT:
  - Stimulus: stop asserted at idx = 4 of byte 0x66.
  - Response: remaining bits 0110 are still emitted; s_ready stays 0; busy falls after idx 0; the match at bit 5 is counted.
- Config while busy ignored:
  - Stimulus: cfg_we with len = 3 during RUN.
  - Response: 11001 detection is unchanged. With CNT_W = 2, pattern 1, len 1 and byte 0xFF, match_cnt saturates at 3.
- Reset mid-operation: rst at idx = 3 → next cycle busy = 0, bit_vld = 0, match_cnt = 0, config back to 11001/5.
